taillight_seq: RTL and testbench

Parametrised sequential tail-light controller, the successor to the fixed 6-lamp `taillight`. It drives N lamps per side with inner-to-outer sequential turn signals, hazard flash, brake and a dimmed running light. Step timing comes from an internal prescaler, and dimming comes from an internal PWM generator, so the separate slow clock and `dimclk` inputs are removed. The block sits between the debounced driver-input logic and the lamp drivers.

---
 rtl/taillight_pkg.sv | 19 +
 rtl/taillight_pwm.sv | 27 ++
 rtl/taillight_seq.sv | 119 +++++++++++
 tb/tb_taillight_seq.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/taillight_pkg.sv
// Shared types and the input-to-mode decode used by the sequential tail-light controller.
package taillight_pkg;

    typedef enum logic [1:0] {
        MODE_IDLE,
        MODE_LEFT,
        MODE_RIGHT,
        MODE_HAZARD
    } mode_e;

    // Both turn stalks together are treated as a hazard request.
    function automatic mode_e decode_mode(input logic left, input logic right, input logic hazard);
        if (hazard || (left && right)) return MODE_HAZARD;
        else if (left)                 return MODE_LEFT;
        else if (right)                return MODE_RIGHT;
        else                           return MODE_IDLE;
    endfunction

endpackage

// File: rtl/taillight_pwm.sv
// Free-running PWM counter producing the dimmed running-light enable.
module taillight_pwm #(
    parameter int PWM_BITS = 4,
    parameter int RUN_DUTY = 3
) (
    input  logic clk,
    input  logic rst,
    output logic dim
);

    localparam logic [PWM_BITS:0] DUTY = (PWM_BITS+1)'(RUN_DUTY);

    if (RUN_DUTY >= (1 << PWM_BITS)) begin : g_duty_check
        $error("taillight_pwm: RUN_DUTY must be below 2**PWM_BITS");
    end

    logic [PWM_BITS-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt <= '0;
        else      cnt <= cnt + PWM_BITS'(1);
    end

    // Extra MSB keeps the compare unsigned and lets RUN_DUTY=0 mean never on.
    assign dim = ({1'b0, cnt} < DUTY);

endmodule

// File: rtl/taillight_seq.sv
// Sequential tail-light controller: N lamps per side, inner-to-outer turn sequence,
// hazard flash, brake and PWM-dimmed running light, all from a single clock.
//
// mode        | meaning
// MODE_IDLE   | no turn; every lamp shows the steady (brake / dim / off) value
// MODE_LEFT   | left side lights ph innermost lamps; ph=0 gap shows steady value
// MODE_RIGHT  | right side lights ph innermost lamps; ph=0 gap shows steady value
// MODE_HAZARD | all lamps full on ph=1, all off ph=0; brake and runlight ignored
module taillight_seq
    import taillight_pkg::*;
#(
    parameter int LAMPS_PER_SIDE = 3,
    parameter int STEP_CYCLES    = 10,
    parameter int PWM_BITS       = 4,
    parameter int RUN_DUTY       = 3
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          left,
    input  logic                          right,
    input  logic                          brake,
    input  logic                          hazard,
    input  logic                          runlight,
    output logic [2*LAMPS_PER_SIDE-1:0]   lights,
    output logic [1:0]                    mode
);

    localparam int N     = LAMPS_PER_SIDE;
    localparam int PH_W  = $clog2(N + 1);
    localparam int PRE_W = $clog2(STEP_CYCLES);

    localparam logic [PRE_W-1:0] PRE_RELOAD = PRE_W'(STEP_CYCLES - 1);
    localparam logic [PH_W-1:0]  PH_LAST    = PH_W'(N);
    localparam logic [PH_W-1:0]  PH_ONE     = PH_W'(1);

    if (N < 2) begin : g_lamps_check
        $error("taillight_seq: LAMPS_PER_SIDE must be at least 2");
    end
    if (STEP_CYCLES < 2) begin : g_step_check
        $error("taillight_seq: STEP_CYCLES must be at least 2");
    end

    mode_e              mode_q, mode_d, mode_new;
    logic [PH_W-1:0]    ph_q, ph_d;
    logic [PRE_W-1:0]   pre_q, pre_d;
    logic               brake_q, run_q;
    logic [2*N-1:0]     lights_q, lights_d;
    logic               tick, steady, dim;

    taillight_pwm #(
        .PWM_BITS (PWM_BITS),
        .RUN_DUTY (RUN_DUTY)
    ) u_pwm (
        .clk (clk),
        .rst (rst),
        .dim (dim)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mode_q   <= MODE_IDLE;
            ph_q     <= '0;
            pre_q    <= PRE_RELOAD;
            brake_q  <= 1'b0;
            run_q    <= 1'b0;
            lights_q <= '0;
        end else begin
            mode_q   <= mode_d;
            ph_q     <= ph_d;
            pre_q    <= pre_d;
            brake_q  <= brake;
            run_q    <= runlight;
            lights_q <= lights_d;
        end
    end

    // Mode change outranks a coincident tick so a new sequence always restarts at one lamp.
    always_comb begin
        mode_new = decode_mode(left, right, hazard);
        tick     = (pre_q == '0);
        mode_d   = mode_new;
        pre_d    = tick ? PRE_RELOAD : pre_q - PRE_W'(1);
        ph_d     = ph_q;
        if (mode_new != mode_q) begin
            pre_d = PRE_RELOAD;
            ph_d  = (mode_new == MODE_IDLE) ? '0 : PH_ONE;
        end else if (tick) begin
            unique case (mode_q)
                MODE_LEFT, MODE_RIGHT: ph_d = (ph_q >= PH_LAST) ? '0 : ph_q + PH_ONE;
                MODE_HAZARD:           ph_d = (ph_q == '0) ? PH_ONE : '0;
                default:               ph_d = '0;
            endcase
        end
    end

    // While a turn side is sequencing its unlit lamps stay dark so the sweep stays visible.
    always_comb begin
        steady   = brake_q | (run_q & dim);
        lights_d = {2*N{steady}};
        unique case (mode_q)
            MODE_HAZARD: lights_d = {2*N{ph_q != '0}};
            MODE_LEFT: begin
                if (ph_q != '0) begin
                    for (int i = 0; i < N; i++) lights_d[N+i] = (PH_W'(i) < ph_q);
                end
            end
            MODE_RIGHT: begin
                if (ph_q != '0) begin
                    for (int i = 0; i < N; i++) lights_d[N-1-i] = (PH_W'(i) < ph_q);
                end
            end
            default: lights_d = {2*N{steady}};
        endcase
    end

    assign lights = lights_q;
    assign mode   = mode_q;

endmodule

// File: tb/tb_taillight_seq.sv
// Self-checking bench for taillight_seq: directed test-plan scenarios plus random input runs
// compared against a timeline-arithmetic reference model.
module tb_taillight_seq;

    localparam int N = 3;
    localparam int S = 4;
    localparam int B = 2;
    localparam int D = 1;
    localparam int W = 2 * N;

    localparam logic [1:0] M_IDLE  = 2'd0;
    localparam logic [1:0] M_LEFT  = 2'd1;
    localparam logic [1:0] M_RIGHT = 2'd2;
    localparam logic [1:0] M_HAZ   = 2'd3;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         left = 1'b0, right = 1'b0, brake = 1'b0, hazard = 1'b0, runlight = 1'b0;
    logic [W-1:0] lights;
    logic [1:0]   mode;

    int passes = 0;
    int total  = 0;

    int           edge_n, seg_start, m_ph, m_cnt;
    logic [1:0]   m_mode;
    bit           m_brk, m_run;
    logic [W-1:0] exp_lights;
    logic [1:0]   exp_mode;

    taillight_seq #(
        .LAMPS_PER_SIDE (N),
        .STEP_CYCLES    (S),
        .PWM_BITS       (B),
        .RUN_DUTY       (D)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .left     (left),
        .right    (right),
        .brake    (brake),
        .hazard   (hazard),
        .runlight (runlight),
        .lights   (lights),
        .mode     (mode)
    );

    always #5 clk = ~clk;

    function automatic logic [1:0] ref_mode(input logic l, input logic r, input logic h);
        if (h || (l && r)) return M_HAZ;
        if (l) return M_LEFT;
        if (r) return M_RIGHT;
        return M_IDLE;
    endfunction

    // Phase as a function of edges elapsed since the mode was entered.
    function automatic int ph_of(input logic [1:0] m, input int el);
        if (m == M_LEFT || m == M_RIGHT) return (1 + el / S) % (N + 1);
        if (m == M_HAZ) return ((el / S) % 2 == 0) ? 1 : 0;
        return 0;
    endfunction

    function automatic logic [W-1:0] model_lamps(input logic [1:0] m, input int ph,
                                                 input bit brk, input bit run, input bit dm);
        logic [W-1:0] r;
        bit st;
        st = brk || (run && dm);
        r  = {W{st}};
        if (m == M_HAZ) begin
            r = (ph == 1) ? {W{1'b1}} : {W{1'b0}};
        end else if (m == M_LEFT && ph != 0) begin
            for (int i = 0; i < N; i++) r[N+i] = (i < ph);
        end else if (m == M_RIGHT && ph != 0) begin
            for (int i = 0; i < N; i++) r[N-1-i] = (i < ph);
        end
        return r;
    endfunction

    task automatic model_reset();
        edge_n     = 0;
        seg_start  = 0;
        m_ph       = 0;
        m_cnt      = 0;
        m_mode     = M_IDLE;
        m_brk      = 0;
        m_run      = 0;
        exp_lights = '0;
        exp_mode   = M_IDLE;
    endtask

    // One clock edge: lamps reflect the state registered on the previous edge.
    task automatic advance();
        logic [1:0] nm;
        bit dm;
        @(posedge clk);
        #1;
        edge_n++;
        dm         = (m_cnt < D);
        exp_lights = model_lamps(m_mode, m_ph, m_brk, m_run, dm);
        nm         = ref_mode(left, right, hazard);
        if (nm != m_mode) seg_start = edge_n;
        m_mode   = nm;
        m_ph     = ph_of(nm, edge_n - seg_start);
        m_brk    = brake;
        m_run    = runlight;
        m_cnt    = edge_n % (1 << B);
        exp_mode = nm;
    endtask

    task automatic apply_reset();
        {left, right, brake, hazard, runlight} = '0;
        @(posedge clk);
        #3 rst = 1'b0;
        @(posedge clk);
        #3 rst = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        apply_reset();
        left = 1'b1;
        repeat (6) begin
            advance();
            total++;
            if (lights !== exp_lights || mode !== exp_mode)
                $display("FAIL reset_pre: lights=%b mode=%0d expected lights=%b mode=%0d edge %0d",
                         lights, mode, exp_lights, exp_mode, edge_n);
            else passes++;
        end
        #2 rst = 1'b0;
        #1;
        total++;
        if (lights !== '0 || mode !== M_IDLE)
            $display("FAIL reset_async: lights=%b mode=%0d expected lights=000000 mode=0", lights, mode);
        else passes++;
        repeat (3) begin
            @(posedge clk);
            #1;
            total++;
            if (lights !== '0 || mode !== M_IDLE)
                $display("FAIL reset_hold: lights=%b mode=%0d expected lights=000000 mode=0", lights, mode);
            else passes++;
        end
        #2 rst = 1'b1;
        model_reset();
        advance();
        total++;
        if (lights !== exp_lights || mode !== exp_mode)
            $display("FAIL reset_release: lights=%b mode=%0d expected lights=%b mode=%0d",
                     lights, mode, exp_lights, exp_mode);
        else passes++;
        left = 1'b0;
    endtask

    task automatic test_brake_run();
        int hi[W];
        apply_reset();
        brake = 1'b1;
        advance();
        total++;
        if (lights !== '0 || lights !== exp_lights)
            $display("FAIL brake_lat1: lights=%b expected 000000", lights);
        else passes++;
        advance();
        total++;
        if (lights !== 6'b111111 || lights !== exp_lights)
            $display("FAIL brake_on: lights=%b expected 111111", lights);
        else passes++;
        brake    = 1'b0;
        runlight = 1'b1;
        repeat (2) advance();
        for (int b = 0; b < W; b++) hi[b] = 0;
        repeat (8) begin
            advance();
            total++;
            if (lights !== exp_lights)
                $display("FAIL run_model: lights=%b expected %b edge %0d", lights, exp_lights, edge_n);
            else passes++;
            for (int b = 0; b < W; b++) hi[b] += int'(lights[b]);
        end
        for (int b = 0; b < W; b++) begin
            total++;
            if (hi[b] != 2)
                $display("FAIL run_duty: bit %0d high %0d of 8 cycles, expected 2", b, hi[b]);
            else passes++;
        end
        runlight = 1'b0;
    endtask

    task automatic test_left_brake();
        logic [2:0] pat[4];
        pat = '{3'b001, 3'b011, 3'b111, 3'b111};
        apply_reset();
        left  = 1'b1;
        brake = 1'b1;
        advance();
        total++;
        if (mode !== M_LEFT) $display("FAIL left_brake_mode: mode=%0d expected 1", mode);
        else passes++;
        for (int k = 0; k < 16; k++) begin
            advance();
            total++;
            if (lights[W-1:N] !== pat[k/4] || lights[N-1:0] !== 3'b111 || lights !== exp_lights)
                $display("FAIL left_brake_step: lights=%b expected %b/%b step %0d",
                         lights, pat[k/4], exp_lights, k);
            else passes++;
        end
    endtask

    task automatic test_left_then_right();
        logic [2:0] lp[4];
        logic [2:0] rp[4];
        lp = '{3'b001, 3'b011, 3'b111, 3'b000};
        rp = '{3'b100, 3'b110, 3'b111, 3'b000};
        apply_reset();
        left = 1'b1;
        advance();
        for (int k = 0; k < 16; k++) begin
            advance();
            total++;
            if (lights[W-1:N] !== lp[k/4] || lights[N-1:0] !== 3'b000 || lights !== exp_lights)
                $display("FAIL left_step: lights=%b expected %b000 step %0d", lights, lp[k/4], k);
            else passes++;
        end
        repeat (4) advance();
        left  = 1'b0;
        right = 1'b1;
        advance();
        total++;
        if (mode !== M_RIGHT || lights !== exp_lights)
            $display("FAIL switch_right: mode=%0d lights=%b expected mode 2 lights %b",
                     mode, lights, exp_lights);
        else passes++;
        for (int k = 0; k < 16; k++) begin
            advance();
            total++;
            if (lights[N-1:0] !== rp[k/4] || lights[W-1:N] !== 3'b000 || lights !== exp_lights)
                $display("FAIL right_step: lights=%b expected 000%b step %0d", lights, rp[k/4], k);
            else passes++;
        end
        right = 1'b0;
    endtask

    task automatic test_hazard();
        logic [W-1:0] want;
        apply_reset();
        hazard = 1'b1;
        brake  = 1'b1;
        advance();
        for (int k = 0; k < 16; k++) begin
            advance();
            want = ((k / 4) % 2 == 0) ? {W{1'b1}} : {W{1'b0}};
            total++;
            if (lights !== want || lights !== exp_lights)
                $display("FAIL hazard_flash: lights=%b expected %b step %0d", lights, want, k);
            else passes++;
        end
        hazard = 1'b0;
        left   = 1'b1;
        right  = 1'b1;
        for (int k = 0; k < 16; k++) begin
            advance();
            want = ((k / 4) % 2 == 0) ? {W{1'b1}} : {W{1'b0}};
            total++;
            if (lights !== want || mode !== M_HAZ || lights !== exp_lights)
                $display("FAIL both_stalks: lights=%b mode=%0d expected %b mode 3 step %0d",
                         lights, mode, want, k);
            else passes++;
        end
        {left, right, brake} = '0;
    endtask

    task automatic test_tick_coincident();
        logic [2:0] want;
        apply_reset();
        left = 1'b1;
        repeat (4) advance();
        left  = 1'b0;
        right = 1'b1;
        advance();
        total++;
        if (mode !== M_RIGHT) $display("FAIL tick_mode: mode=%0d expected 2", mode);
        else passes++;
        for (int k = 0; k < 8; k++) begin
            advance();
            want = (k < 4) ? 3'b100 : 3'b110;
            total++;
            if (lights[N-1:0] !== want || lights[W-1:N] !== 3'b000 || lights !== exp_lights)
                $display("FAIL tick_restart: lights=%b expected 000%b step %0d", lights, want, k);
            else passes++;
        end
        right = 1'b0;
    endtask

    task automatic test_random();
        int hold;
        apply_reset();
        repeat (40) begin
            left     = 1'($urandom_range(0, 1));
            right    = 1'($urandom_range(0, 1));
            brake    = 1'($urandom_range(0, 1));
            runlight = 1'($urandom_range(0, 1));
            hazard   = ($urandom_range(0, 5) == 0);
            hold     = $urandom_range(1, 20);
            repeat (hold) begin
                advance();
                total++;
                if (lights !== exp_lights || mode !== exp_mode)
                    $display("FAIL random: lights=%b mode=%0d expected lights=%b mode=%0d edge %0d",
                             lights, mode, exp_lights, exp_mode, edge_n);
                else passes++;
            end
        end
        {left, right, brake, hazard, runlight} = '0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_brake_run();
        test_left_brake();
        test_left_then_right();
        test_hazard();
        test_tick_coincident();
        test_random();
        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
